// File: rtl/wb_arb.sv
// wb_arb: three-source writeback arbiter with per-source FIFOs and round-robin grant.
// Optional WB_ARB_STATS_EN adds the wb_conflicts contention counter.
module wb_arb #(
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  src_valid,
  output logic [2:0]  src_ready,
  input  logic [20:0] src_robid,
  input  logic [95:0] src_result,
  input  logic [2:0]  src_error,
  input  logic [14:0] src_ecause,
  input  logic        rob_flush,
  output logic        wb_valid,
  output logic [6:0]  wb_robid,
  output logic [31:0] wb_result,
  output logic        wb_error,
  output logic [4:0]  wb_ecause
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0] wb_conflicts
`endif
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(QDEPTH);
  logic [2:0]  ne;
  logic [44:0] head [3];
  logic [1:0]  last_grant, p0, p1, gnt;
  logic        any;
  always_comb begin
    p0  = last_grant == 2'd2 ? 2'd0 : last_grant + 2'd1;
    p1  = p0 == 2'd2 ? 2'd0 : p0 + 2'd1;
    gnt = ne[p0] ? p0 : ne[p1] ? p1 : last_grant;
    any = |ne;
  end
  for (genvar i = 0; i < 3; i++) begin : g_src
    logic [44:0]   mem [QDEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          push, pop;
    assign src_ready[i] = cnt != FULL;
    assign ne[i]        = cnt != '0;
    assign head[i]      = mem[rp];
    assign push         = src_valid[i] & src_ready[i];
    assign pop          = any & (gnt == 2'(i));
    always_ff @(posedge clk) begin
      if (rst || rob_flush) begin
        cnt <= '0;
        wp  <= '0;
        rp  <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
    always_ff @(posedge clk)
      if (push) mem[wp] <= {src_robid[7*i+:7], src_result[32*i+:32], src_error[i], src_ecause[5*i+:5]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_robid   <= '0;
      wb_result  <= '0;
      wb_error   <= 1'b0;
      wb_ecause  <= '0;
      last_grant <= 2'd2;
    end else if (rob_flush) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= any;
      if (any) begin
        {wb_robid, wb_result, wb_error, wb_ecause} <= head[gnt];
        last_grant <= gnt;
      end
    end
  end
`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk)
    if (rst) wb_conflicts <= '0;
    else if ((ne[0] & ne[1]) | (ne[0] & ne[2]) | (ne[1] & ne[2])) wb_conflicts <= wb_conflicts + 32'd1;
`endif
endmodule

// File: tb/tb_wb_arb.sv
// tb_wb_arb: scoreboard bench for wb_arb; per-source expected queues, head-of-queue matching.
module tb_wb_arb;
  typedef logic [44:0] beat_t;
  logic        clk = 1'b0, rst = 1'b1, rob_flush = 1'b0;
  logic [2:0]  src_valid = '0, src_error = '0, src_ready;
  logic [20:0] src_robid = '0;
  logic [95:0] src_result = '0;
  logic [14:0] src_ecause = '0;
  logic        wb_valid, wb_error;
  logic [6:0]  wb_robid;
  logic [31:0] wb_result;
  logic [4:0]  wb_ecause;
`ifdef WB_ARB_STATS_EN
  logic [31:0] wb_conflicts;
`endif
  wb_arb dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready),
    .src_robid(src_robid), .src_result(src_result), .src_error(src_error),
    .src_ecause(src_ecause), .rob_flush(rob_flush), .wb_valid(wb_valid),
    .wb_robid(wb_robid), .wb_result(wb_result), .wb_error(wb_error), .wb_ecause(wb_ecause)
`ifdef WB_ARB_STATS_EN
    , .wb_conflicts(wb_conflicts)
`endif
  );
  always #5 clk = ~clk;
  int passed = 0, total = 0;
  beat_t stim [3][$];
  beat_t exp_q [3][$];
  logic [6:0] seen [$];
  logic mul_stall = 1'b0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int pending();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
  endfunction
  task automatic clear_exp();
    for (int i = 0; i < 3; i++) exp_q[i].delete();
  endtask
  task automatic drive_all();
    int cyc = 0;
    logic [2:0] v, r;
    while ((stim[0].size() + stim[1].size() + stim[2].size()) > 0 && cyc < 200) begin
      for (int i = 0; i < 3; i++) begin
        v[i] = stim[i].size() > 0;
        if (v[i]) {src_robid[7*i+:7], src_result[32*i+:32], src_error[i], src_ecause[5*i+:5]} = stim[i][0];
      end
      src_valid = v;
      r = src_ready;
      if (v[1] && !r[1]) mul_stall = 1'b1;
      tick();
      for (int i = 0; i < 3; i++)
        if (v[i] && r[i]) exp_q[i].push_back(stim[i].pop_front());
      cyc++;
    end
    src_valid = '0;
    chk("drive_timeout", 64'(cyc < 200), 64'd1);
  endtask
  task automatic drain();
    int c = 0;
    while (pending() > 0 && c < 100) begin
      tick();
      c++;
    end
    chk("drain", 64'(pending()), 64'd0);
    tick();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_exp();
  endtask
  // Any beat must be the head of the queue of the source that owns its robid.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      int found;
      found = -1;
      for (int i = 0; i < 3; i++)
        if (found < 0 && exp_q[i].size() > 0 && exp_q[i][0][44:38] == wb_robid) found = i;
      seen.push_back(wb_robid);
      chk("beat_expected", 64'(found >= 0), 64'd1);
      if (found >= 0) chk("beat", 64'({wb_robid, wb_result, wb_error, wb_ecause}), 64'(exp_q[found].pop_front()));
    end
  end
  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_ready", 64'(src_ready), 64'd7);
    chk("rst_robid", 64'(wb_robid), 64'd0);
    chk("rst_result", 64'(wb_result), 64'd0);
    rst = 1'b0;
    stim[0].push_back({7'd5, 32'h12345678, 1'b0, 5'd0});
    drive_all();
    tick();
    chk("lat_valid", 64'(wb_valid), 64'd1);
    chk("lat_robid", 64'(wb_robid), 64'd5);
    tick();
    chk("idle_valid", 64'(wb_valid), 64'd0);
    chk("hold_robid", 64'(wb_robid), 64'd5);
    chk("hold_result", 64'(wb_result), 64'h12345678);
    do_reset();
    seen.delete();
    for (int i = 0; i < 3; i++) stim[i].push_back({7'(i + 1), 32'(100 + i), 1'b0, 5'd0});
    drive_all();
    drain();
    chk("rr_count", 64'(seen.size()), 64'd3);
    for (int i = 0; i < 3 && i < seen.size(); i++) chk("rr_order", 64'(seen[i]), 64'(i + 1));
`ifdef WB_ARB_STATS_EN
    chk("conflicts", 64'(wb_conflicts), 64'd2);
`endif
    for (int k = 0; k < 3; k++) begin
      stim[0].push_back({7'(30 + k), 32'(k), 1'b0, 5'd0});
      stim[1].push_back({7'(20 + k), 32'hA0 + 32'(k), 1'b0, 5'd0});
      stim[2].push_back({7'(70 + k), 32'hB0 + 32'(k), 1'b0, 5'd0});
    end
    drive_all();
    chk("mul_full", 64'(mul_stall), 64'd1);
    drain();
    stim[2].push_back({7'd40, 32'hDEADBEEF, 1'b1, 5'd13});
    drive_all();
    tick();
    chk("err_flag", 64'(wb_error), 64'd1);
    chk("err_cause", 64'(wb_ecause), 64'd13);
    chk("err_robid", 64'(wb_robid), 64'd40);
    drain();
    for (int k = 0; k < 12; k++)
      for (int i = 0; i < 3; i++)
        stim[i].push_back({7'(i * 40 + k), 32'($urandom), 1'($urandom), 5'($urandom)});
    drive_all();
    drain();
    for (int k = 0; k < 3; k++) begin
      stim[0].push_back({7'(10 + k), 32'(k), 1'b0, 5'd0});
      stim[2].push_back({7'(74 + k), 32'(k), 1'b0, 5'd0});
    end
    drive_all();
    rob_flush = 1'b1;
    src_valid = 3'b001;
    src_robid[6:0] = 7'd9;
    tick();
    rob_flush = 1'b0;
    src_valid = '0;
    clear_exp();
    seen.delete();
    chk("flush_valid", 64'(wb_valid), 64'd0);
    chk("flush_ready", 64'(src_ready), 64'd7);
    for (int k = 0; k < 8; k++) tick();
    chk("flush_silent", 64'(seen.size()), 64'd0);
    for (int i = 0; i < 3; i++) stim[i].push_back({7'(60 + i), 32'(i), 1'b0, 5'd0});
    drive_all();
    rst = 1'b1;
    rob_flush = 1'b1;
    tick();
    chk("rst_fl_valid", 64'(wb_valid), 64'd0);
    chk("rst_fl_ready", 64'(src_ready), 64'd7);
    rst = 1'b0;
    rob_flush = 1'b0;
    clear_exp();
    tick();
    seen.delete();
    stim[1].push_back({7'd50, 32'd1, 1'b0, 5'd0});
    stim[0].push_back({7'd51, 32'd2, 1'b0, 5'd0});
    drive_all();
    drain();
    chk("post_rst_n", 64'(seen.size()), 64'd2);
    if (seen.size() > 0) chk("post_rst_alu", 64'(seen[0]), 64'd51);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
